frame_level_meter: RTL and testbench
====================================

// Module: frame_level_meter
// PURPOSE
//  Consumes the AXI-Stream sample beat stream from the skid buffer output; frames are delimited by s_last.
//  Per frame: computes peak |x|, sum of squares, sample count, and RMS = isqrt(floor(sum_sq/count)).
//  Emits one result beat per frame on a valid/ready output, toward the CSR/reporting stage.
// PARAMETERS
//  DATA_W          16  signed sample width
//  MAX_FRAME_LOG2  16  max frame length = 2**MAX_FRAME_LOG2 samples
//  (derived) CNT_W = MAX_FRAME_LOG2+1; ACC_W = 2*DATA_W+MAX_FRAME_LOG2
// PORTS
//  clk         in   1       clock
//  rst_n       in   1       asynchronous active-low reset
//  s_valid     in   1       sample valid
//  s_ready     out  1       sample ready
//  s_data      in   DATA_W  signed sample
//  s_last      in   1       last sample of frame
//  m_valid     out  1       result valid
//  m_ready     in   1       result accepted
//  m_peak      out  DATA_W  unsigned peak |x|, so -2**(DATA_W-1) maps to 2**(DATA_W-1)
//  m_rms       out  DATA_W  unsigned floor RMS
//  m_count     out  CNT_W   samples in frame (>=1)
//  m_trunc     out  1       frame closed by the length limit, not by s_last
// BEHAVIOUR
//  Interface: one clock clk; reset rst_n is asynchronous, active-low.
//  Reset clears all registers: state=ACCUM; m_valid/m_peak/m_rms/m_count/m_trunc = 0; accumulators = 0.
//   A partial frame in progress at reset is discarded.
//  s_ready = (state==ACCUM), combinational from state only. A beat transfers when s_valid && s_ready.
//  ACCUM, on each accepted beat:
//   - peak <= max(peak, |s_data|)
//   - sum_sq += s_data*s_data, computed unsigned 2*DATA_W wide, accumulated ACC_W wide
//   - count += 1
//   - Beat with s_last=1 closes the frame (sample included): go to DIV, trunc=0.
//   - Beat raising count to 2**MAX_FRAME_LOG2 with s_last=0 closes the frame with trunc=1.
//     Following beats start a new frame.
//  DIV: restoring divide sum_sq/count, 1 quotient bit per cycle, exactly ACC_W cycles, then SQRT.
//   No div-by-zero case: count>=1.
//  SQRT: bitwise isqrt of the quotient's low 2*DATA_W bits, exactly DATA_W cycles, then OUT.
//   The quotient never exceeds 2**(2*DATA_W-2).
//  OUT: result regs loaded on entry; m_valid=1; outputs held stable until m_ready.
//   On m_valid&&m_ready: m_valid=0, accumulators cleared, state=ACCUM.
//  Latency: closing beat -> m_valid high = ACC_W+DATA_W+1 cycles (65 at defaults).
//  No input accepted in DIV/SQRT/OUT: the upstream skid buffer absorbs the stall.
//  m_valid must not drop without m_ready; result regs change only on OUT entry.
// CONFIGURATION
//  Macro LEVEL_METER_THRESH_EN.
//  Defined: adds ports
//   - thr_peak in  DATA_W  unsigned
//   - thr_rms  in  DATA_W  unsigned
//   - m_peak_exc out 1 = (m_peak > thr_peak), strict
//   - m_rms_exc  out 1 = (m_rms > thr_rms), strict
//   Thresholds sampled on OUT entry; flags held with the result; reset 0.
//  Undefined: those ports and their logic are absent; all other behaviour identical.
// STRUCTURE
//  Package level_meter_pkg: state enum typedef {ACCUM,DIV,SQRT,OUT}; functions cnt_w(), acc_w().
//  Sub-module seq_isqrt:
//   - start/done handshake; 2*DATA_W radicand in, DATA_W root out
//   - fixed DATA_W-cycle iteration
//   - divider stays inline in frame_level_meter.
// TESTING
//  1 Frame {3,-4(last)} -> peak 4, count 2, sum 25, quotient 12, rms 3, trunc 0, m_valid 65 cycles after the last beat.
//  2 Frame {-32768(last)} -> peak 32768 (0x8000), rms 32768, count 1.
//  3 m_ready low 10 cycles in OUT -> m_valid held, outputs stable, s_ready 0; next frame accepted only after the handshake.
//  4 MAX_FRAME_LOG2=2, six beats of 1, last on the 6th:
//    -> result A: count 4, trunc 1, rms 1; result B: count 2, trunc 0, rms 1.
//  5 rst_n low mid-DIV -> all outputs 0, s_ready 1 after release; frame {5(last)} -> peak 5, rms 5.
//  6 THRESH_EN, thr_peak=4, thr_rms=4:
//    - frame {4} -> peak_exc 0, rms_exc 0
//    - frame {5} -> peak_exc 1, rms_exc 1

Source files
------------

// File: rtl/level_meter_pkg.sv
// Shared types and width helpers for the frame level meter.
package level_meter_pkg;

    typedef enum logic [1:0] {ACCUM, DIV, SQRT, OUT} meter_state_t;

    function automatic int cnt_w(input int max_frame_log2);
        return max_frame_log2 + 1;
    endfunction

    function automatic int acc_w(input int data_w, input int max_frame_log2);
        return 2 * data_w + max_frame_log2;
    endfunction

endpackage

// File: rtl/seq_isqrt.sv
// Sequential bitwise integer square root: one root bit per cycle, DATA_W cycles after start.
module seq_isqrt #(
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2*DATA_W-1:0]   radicand,
    output logic                  done,
    output logic [DATA_W-1:0]     root
);

    localparam int RW = DATA_W + 2;
    localparam int CW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    logic [2*DATA_W-1:0] rad;
    logic [RW-1:0]       rem;
    logic [CW-1:0]       cnt;
    logic                busy;
    logic [RW+1:0]       rem_sh;
    logic [RW+1:0]       trial;
    logic [RW+1:0]       diff;
    logic                ge;

    // Bring down the next radicand digit pair and try the candidate root bit.
    always_comb begin
        rem_sh = {rem, rad[2*DATA_W-1 -: 2]};
        trial  = {2'b00, root, 2'b01};
        diff   = rem_sh - trial;
        ge     = (rem_sh >= trial);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rad  <= '0;
            rem  <= '0;
            root <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else if (start) begin
            rad  <= radicand;
            rem  <= '0;
            root <= '0;
            cnt  <= '0;
            busy <= 1'b1;
            done <= 1'b0;
        end else if (busy) begin
            rad  <= {rad[2*DATA_W-3:0], 2'b00};
            rem  <= ge ? RW'(diff) : RW'(rem_sh);
            root <= {root[DATA_W-2:0], ge};
            cnt  <= cnt + CW'(1);
            if (cnt == LAST) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: rtl/frame_level_meter.sv
// Per-frame peak / RMS / count meter on an AXI-Stream sample stream.
// Optional threshold flags are built when LEVEL_METER_THRESH_EN is defined.
module frame_level_meter
    import level_meter_pkg::*;
#(
    parameter int DATA_W         = 16,
    parameter int MAX_FRAME_LOG2 = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                s_valid,
    output logic                                s_ready,
    input  logic signed [DATA_W-1:0]            s_data,
    input  logic                                s_last,
    output logic                                m_valid,
    input  logic                                m_ready,
    output logic [DATA_W-1:0]                   m_peak,
    output logic [DATA_W-1:0]                   m_rms,
    output logic [cnt_w(MAX_FRAME_LOG2)-1:0]    m_count,
    output logic                                m_trunc
`ifdef LEVEL_METER_THRESH_EN
    ,
    input  logic [DATA_W-1:0]                   thr_peak,
    input  logic [DATA_W-1:0]                   thr_rms,
    output logic                                m_peak_exc,
    output logic                                m_rms_exc
`endif
);

    localparam int CNT_W  = cnt_w(MAX_FRAME_LOG2);
    localparam int ACC_W  = acc_w(DATA_W, MAX_FRAME_LOG2);
    localparam int DIVC_W = $clog2(ACC_W);
    localparam logic [CNT_W-1:0]  FRAME_MAX = {1'b1, {MAX_FRAME_LOG2{1'b0}}};
    localparam logic [DIVC_W-1:0] DIV_LAST  = DIVC_W'(ACC_W - 1);

    // |x| as unsigned; the most negative code maps to 2**(DATA_W-1).
    function automatic logic [DATA_W-1:0] abs_u(input logic signed [DATA_W-1:0] x);
        logic [DATA_W-1:0] u;
        u = x;
        return x[DATA_W-1] ? -u : u;
    endfunction

    meter_state_t state, state_nxt;

    logic [DATA_W-1:0]   peak;
    logic [ACC_W-1:0]    sum_sq;
    logic [CNT_W-1:0]    count;
    logic                trunc;
    logic [CNT_W-1:0]    rem;
    logic [DIVC_W-1:0]   div_cnt;

    logic                beat;
    logic [DATA_W-1:0]   ax;
    logic [2*DATA_W-1:0] sq;
    logic [CNT_W-1:0]    count_inc;
    logic                len_full;
    logic [CNT_W:0]      trial;
    logic [CNT_W:0]      diff;
    logic                ge;
    logic [CNT_W-1:0]    rem_nxt;
    logic [ACC_W-1:0]    quo_nxt;
    logic                sq_start;
    logic                sq_done;
    logic [DATA_W-1:0]   sq_root;

    assign s_ready = (state == ACCUM);
    assign m_valid = (state == OUT);
    assign beat    = s_valid && s_ready;

    // sum_sq doubles as the dividend/quotient shift register during DIV.
    always_comb begin
        ax        = abs_u(s_data);
        sq        = {{DATA_W{1'b0}}, ax} * {{DATA_W{1'b0}}, ax};
        count_inc = count + CNT_W'(1);
        len_full  = (count_inc == FRAME_MAX);
        trial     = {rem, sum_sq[ACC_W-1]};
        diff      = trial - {1'b0, count};
        ge        = (trial >= {1'b0, count});
        rem_nxt   = ge ? CNT_W'(diff) : CNT_W'(trial);
        quo_nxt   = {sum_sq[ACC_W-2:0], ge};
        sq_start  = (state == DIV) && (div_cnt == DIV_LAST);
    end

    seq_isqrt #(
        .DATA_W (DATA_W)
    ) u_isqrt (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (sq_start),
        .radicand (quo_nxt[2*DATA_W-1:0]),
        .done     (sq_done),
        .root     (sq_root)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ACCUM;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM: if (beat && (s_last || len_full)) state_nxt = DIV;
            DIV:   if (div_cnt == DIV_LAST)          state_nxt = SQRT;
            SQRT:  if (sq_done)                      state_nxt = OUT;
            OUT:   if (m_ready)                      state_nxt = ACCUM;
            default:                                 state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak    <= '0;
            sum_sq  <= '0;
            count   <= '0;
            trunc   <= 1'b0;
            rem     <= '0;
            div_cnt <= '0;
            m_peak  <= '0;
            m_rms   <= '0;
            m_count <= '0;
            m_trunc <= 1'b0;
`ifdef LEVEL_METER_THRESH_EN
            m_peak_exc <= 1'b0;
            m_rms_exc  <= 1'b0;
`endif
        end else begin
            case (state)
                ACCUM: if (beat) begin
                    peak    <= (ax > peak) ? ax : peak;
                    sum_sq  <= sum_sq + {{MAX_FRAME_LOG2{1'b0}}, sq};
                    count   <= count_inc;
                    trunc   <= !s_last && len_full;
                    rem     <= '0;
                    div_cnt <= '0;
                end
                DIV: begin
                    sum_sq  <= quo_nxt;
                    rem     <= rem_nxt;
                    div_cnt <= div_cnt + DIVC_W'(1);
                end
                SQRT: if (sq_done) begin
                    m_peak  <= peak;
                    m_rms   <= sq_root;
                    m_count <= count;
                    m_trunc <= trunc;
`ifdef LEVEL_METER_THRESH_EN
                    m_peak_exc <= (peak > thr_peak);
                    m_rms_exc  <= (sq_root > thr_rms);
`endif
                end
                OUT: if (m_ready) begin
                    peak   <= '0;
                    sum_sq <= '0;
                    count  <= '0;
                    trunc  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_level_meter.sv
// Randomized bench for frame_level_meter: default instance plus a 4-sample-limit instance.
module tb_frame_level_meter;

    localparam int DW   = 16;
    localparam int LAT0 = 2*DW + 16 + DW + 1;
    localparam int LAT1 = 2*DW + 2 + DW + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic                 s_valid_a [2];
    logic signed [DW-1:0] s_data_a  [2];
    logic                 s_last_a  [2];
    logic                 m_ready_a [2];
    wire                  s_ready_a [2];
    wire                  m_valid_a [2];
    wire [DW-1:0]         m_peak_a  [2];
    wire [DW-1:0]         m_rms_a   [2];
    wire [16:0]           m_count_a [2];
    wire                  m_trunc_a [2];
    wire [2:0]            m_count1;

    assign m_count_a[1] = {14'd0, m_count1};

`ifdef LEVEL_METER_THRESH_EN
    logic [DW-1:0] thr = 16'd4;
    wire           pexc_a [2];
    wire           rexc_a [2];
`endif

    frame_level_meter dut0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid_a[0]),
        .s_ready (s_ready_a[0]),
        .s_data  (s_data_a[0]),
        .s_last  (s_last_a[0]),
        .m_valid (m_valid_a[0]),
        .m_ready (m_ready_a[0]),
        .m_peak  (m_peak_a[0]),
        .m_rms   (m_rms_a[0]),
        .m_count (m_count_a[0]),
        .m_trunc (m_trunc_a[0])
`ifdef LEVEL_METER_THRESH_EN
        ,
        .thr_peak   (thr),
        .thr_rms    (thr),
        .m_peak_exc (pexc_a[0]),
        .m_rms_exc  (rexc_a[0])
`endif
    );

    frame_level_meter #(
        .DATA_W         (DW),
        .MAX_FRAME_LOG2 (2)
    ) dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid_a[1]),
        .s_ready (s_ready_a[1]),
        .s_data  (s_data_a[1]),
        .s_last  (s_last_a[1]),
        .m_valid (m_valid_a[1]),
        .m_ready (m_ready_a[1]),
        .m_peak  (m_peak_a[1]),
        .m_rms   (m_rms_a[1]),
        .m_count (m_count1),
        .m_trunc (m_trunc_a[1])
`ifdef LEVEL_METER_THRESH_EN
        ,
        .thr_peak   (thr),
        .thr_rms    (thr),
        .m_peak_exc (pexc_a[1]),
        .m_rms_exc  (rexc_a[1])
`endif
    );

    typedef struct {
        int d;
        int peak;
        int rms;
        int cnt;
        bit trunc;
        int close;
    } exp_t;

    exp_t   exp_q[$];
    longint acc_sum  [2];
    int     acc_peak [2];
    int     acc_cnt  [2];
    int     lim      [2];
    int     force_hold [2];
    bit     mon_busy [2];
    int     n_cmp = 0;
    int     n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int isqrt_ref(input longint q);
        longint r;
        r = longint'($floor($sqrt(real'(q))));
        while (r * r > q) r--;
        while ((r + 1) * (r + 1) <= q) r++;
        return int'(r);
    endfunction

    function automatic int rnd_sample();
        case ($urandom_range(0, 7))
            0:       return -32768;
            1:       return 32767;
            2:       return int'($urandom_range(0, 15)) - 8;
            default: return int'($urandom_range(0, 65535)) - 32768;
        endcase
    endfunction

    // Called at a negedge; returns at a negedge with the beat transferred.
    task automatic drive_beat(input int d, input int x, input bit last, input bit model);
        int   g;
        int   edge_i;
        int   a;
        exp_t e;
        s_valid_a[d] = 1'b1;
        s_data_a[d]  = DW'(x);
        s_last_a[d]  = last;
        g = 0;
        while (s_ready_a[d] !== 1'b1 && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (g >= 500) check($sformatf("s_ready_wait%0d", d), 0, 1);
        edge_i = cyc + 1;
        @(negedge clk);
        s_valid_a[d] = 1'b0;
        s_last_a[d]  = 1'b0;
        if (model) begin
            a = (x < 0) ? -x : x;
            if (a > acc_peak[d]) acc_peak[d] = a;
            acc_sum[d] += longint'(a) * longint'(a);
            acc_cnt[d]++;
            if (last || acc_cnt[d] == lim[d]) begin
                e.d     = d;
                e.peak  = acc_peak[d];
                e.cnt   = acc_cnt[d];
                e.trunc = !last;
                e.rms   = isqrt_ref(acc_sum[d] / acc_cnt[d]);
                e.close = edge_i;
                exp_q.push_back(e);
                acc_sum[d]  = 0;
                acc_peak[d] = 0;
                acc_cnt[d]  = 0;
            end
        end
    endtask

    task automatic send_frame(input int d, input int xs[$], input bit model);
        for (int i = 0; i < xs.size(); i++) begin
            repeat ($urandom_range(0, 1)) @(negedge clk);
            drive_beat(d, xs[i], i == xs.size() - 1, model);
        end
    endtask

    task automatic monitor(input int d);
        exp_t          e;
        bit            found;
        int            hold;
        bit            ok;
        logic [DW-1:0] pk;
        logic [DW-1:0] rm;
        logic [16:0]   ct;
        logic          tr;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1 || m_valid_a[d] !== 1'b1) continue;
            mon_busy[d] = 1'b1;
            found = 1'b0;
            for (int i = 0; i < exp_q.size(); i++) begin
                if (exp_q[i].d == d) begin
                    e = exp_q[i];
                    exp_q.delete(i);
                    found = 1'b1;
                    break;
                end
            end
            if (!found) begin
                check($sformatf("unexpected_valid%0d", d), 1, 0);
            end else begin
                check($sformatf("latency%0d", d), cyc, e.close + ((d == 0) ? LAT0 : LAT1));
                check($sformatf("peak%0d", d), m_peak_a[d], e.peak);
                check($sformatf("rms%0d", d), m_rms_a[d], e.rms);
                check($sformatf("count%0d", d), m_count_a[d], e.cnt);
                check($sformatf("trunc%0d", d), m_trunc_a[d], e.trunc);
`ifdef LEVEL_METER_THRESH_EN
                check($sformatf("peak_exc%0d", d), pexc_a[d], e.peak > 4);
                check($sformatf("rms_exc%0d", d), rexc_a[d], e.rms > 4);
`endif
            end
            hold = (force_hold[d] > 0) ? force_hold[d] : $urandom_range(0, 3);
            force_hold[d] = 0;
            pk = m_peak_a[d];
            rm = m_rms_a[d];
            ct = m_count_a[d];
            tr = m_trunc_a[d];
            ok = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                if (m_valid_a[d] !== 1'b1 || m_peak_a[d] !== pk || m_rms_a[d] !== rm ||
                    m_count_a[d] !== ct || m_trunc_a[d] !== tr || s_ready_a[d] !== 1'b0)
                    ok = 1'b0;
            end
            if (hold > 0) check($sformatf("hold_stable%0d", d), ok, 1);
            m_ready_a[d] = 1'b1;
            @(negedge clk);
            m_ready_a[d] = 1'b0;
            check($sformatf("valid_drop%0d", d), m_valid_a[d], 0);
            check($sformatf("ready_after%0d", d), s_ready_a[d], 1);
            mon_busy[d] = 1'b0;
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    task automatic drain();
        int g;
        g = 0;
        while ((exp_q.size() != 0 || mon_busy[0] || mon_busy[1]) && g < 3000) begin
            @(negedge clk);
            g++;
        end
        check("drain_done", (g < 3000), 1);
    endtask

    initial begin
        int fr[$];
        int n;
        bit seen;

        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            s_valid_a[d]  = 1'b0;
            s_data_a[d]   = '0;
            s_last_a[d]   = 1'b0;
            m_ready_a[d]  = 1'b0;
            acc_sum[d]    = 0;
            acc_peak[d]   = 0;
            acc_cnt[d]    = 0;
            force_hold[d] = 0;
            mon_busy[d]   = 1'b0;
        end
        lim[0] = 65536;
        lim[1] = 4;

        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_m_valid%0d", d), m_valid_a[d], 0);
            check($sformatf("rst_m_peak%0d", d), m_peak_a[d], 0);
            check($sformatf("rst_m_count%0d", d), m_count_a[d], 0);
            check($sformatf("rst_s_ready%0d", d), s_ready_a[d], 1);
        end
        rst_n = 1'b1;
        @(negedge clk);

        fr = {3, -4};
        send_frame(0, fr, 1);
        fr = {-32768};
        send_frame(0, fr, 1);
        drain();

        force_hold[0] = 10;
        fr = {100, -200, 300};
        send_frame(0, fr, 1);
        fr = {1, 2};
        send_frame(0, fr, 1);
        fr = {4};
        send_frame(0, fr, 1);
        fr = {5};
        send_frame(0, fr, 1);

        fr = {1, 1, 1, 1, 1, 1};
        send_frame(1, fr, 1);

        for (int f = 0; f < 25; f++) begin
            fr.delete();
            n = $urandom_range(1, 24);
            for (int i = 0; i < n; i++) fr.push_back(rnd_sample());
            send_frame(0, fr, 1);
            fr.delete();
            n = $urandom_range(1, 9);
            for (int i = 0; i < n; i++) fr.push_back(rnd_sample());
            send_frame(1, fr, 1);
        end
        drain();

        fr = {7, 9};
        send_frame(0, fr, 0);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_m_valid", m_valid_a[0], 0);
        check("midrst_m_peak", m_peak_a[0], 0);
        check("midrst_m_rms", m_rms_a[0], 0);
        check("midrst_m_count", m_count_a[0], 0);
        check("midrst_m_trunc", m_trunc_a[0], 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("midrst_s_ready", s_ready_a[0], 1);
        seen = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (m_valid_a[0] === 1'b1) seen = 1'b1;
        end
        check("midrst_discard", seen, 0);
        fr = {5};
        send_frame(0, fr, 1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
